// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-formatting helpers for the
// load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } lsu_state_e;

   // Unknown size codes, signed-less stores and misaligned H/W are rejected.
   function automatic logic f_illegal(input logic i_we, input logic [2:0] i_f3,
                                      input logic [1:0] i_lo);
      logic bad;
      bad = 1'b0;
      case (i_f3)
         F3_LB, F3_LBU: bad = 1'b0;
         F3_LH, F3_LHU: bad = i_lo[0];
         F3_LW:         bad = (i_lo != 2'b00);
         default:       bad = 1'b1;
      endcase
      if (i_we && i_f3[2]) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [3:0] f_be(input logic [1:0] i_size, input logic [1:0] i_lo);
      case (i_size)
         2'b00:   return 4'b0001 << i_lo;
         2'b01:   return i_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] i_size, input logic [31:0] i_wd);
      case (i_size)
         2'b00:   return {4{i_wd[7:0]}};
         2'b01:   return {2{i_wd[15:0]}};
         default: return i_wd;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Byte-enabled data-memory request/response bus between the LSU and memory.
interface lsu_if #(
   parameter int MEM_ADDR_WIDTH = 6
);
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic                      mem_we;
   logic [3:0]                mem_be;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]               mem_wdata;
   logic                      mem_rsp_valid;
   logic [31:0]               mem_rdata;

   modport master (
      output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction with sign or zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_result = i_rdata;
      case (i_funct3)
         F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_result = {24'd0, w_byte};
         F3_LH:   o_result = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_result = {16'd0, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: validates one command, issues a single memory request,
// waits for the response and returns aligned load data with a done pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 6,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lsu_valid,
   input  logic                  lsu_we,
   input  logic [2:0]            lsu_funct3,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [31:0]           lsu_wdata,
   output logic                  lsu_busy,
   output logic                  lsu_done,
   output logic                  lsu_err,
   output logic [31:0]           lsu_rdata,
   lsu_if.master                 mem
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AQ_W  = MEM_ADDR_WIDTH + 2;

   lsu_state_e        r_state, w_next;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [AQ_W-1:0]   r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic [31:0]       r_rdata;
   logic              w_issue_err;
   logic              w_timeout;
   logic              w_in_req;
   logic [31:0]       w_load;
   logic              w_unused_addr;

   // Only the word-address and lane bits reach memory.
   assign w_unused_addr = ^lsu_addr[ADDR_WIDTH-1:AQ_W];

   assign w_issue_err = f_illegal(lsu_we, lsu_funct3, lsu_addr[1:0]);
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // A handshake in the last counted cycle still takes priority over timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (lsu_valid) w_next = w_issue_err ? ST_DONE : ST_REQ;
         ST_REQ:      if (mem.mem_req_ready)      w_next = ST_WAIT_RSP;
                      else if (w_timeout)         w_next = ST_DONE;
         ST_WAIT_RSP: if (mem.mem_rsp_valid)      w_next = ST_DONE;
                      else if (w_timeout)         w_next = ST_DONE;
         default:     w_next = ST_IDLE;
      endcase
   end

   lsu_load_align u_align (
      .i_rdata   (mem.mem_rdata),
      .i_funct3  (r_f3),
      .i_addr_lo (r_addr[1:0]),
      .o_result  (w_load)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_f3    <= 3'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: if (lsu_valid) begin
               r_we    <= lsu_we;
               r_f3    <= lsu_funct3;
               r_addr  <= lsu_addr[AQ_W-1:0];
               r_wdata <= lsu_wdata;
               r_cnt   <= '0;
               r_err   <= w_issue_err;
               if (w_issue_err) r_rdata <= 32'd0;
            end
            ST_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (!mem.mem_req_ready && w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= 32'd0;
               end
            end
            ST_WAIT_RSP: begin
               r_cnt <= r_cnt + 1'b1;
               if (mem.mem_rsp_valid) begin
                  r_rdata <= r_we ? 32'd0 : w_load;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_in_req          = (r_state == ST_REQ);
   assign lsu_busy          = (r_state != ST_IDLE);
   assign lsu_done          = (r_state == ST_DONE);
   assign lsu_err           = lsu_done & r_err;
   assign lsu_rdata         = r_rdata;
   assign mem.mem_req_valid = w_in_req;
   assign mem.mem_we        = w_in_req & r_we;
   assign mem.mem_be        = w_in_req ? f_be(r_f3[1:0], r_addr[1:0]) : 4'd0;
   assign mem.mem_addr      = w_in_req ? r_addr[AQ_W-1:2] : '0;
   assign mem.mem_wdata     = w_in_req ? f_wdata(r_f3[1:0], r_wdata) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-arithmetic
// reference model of the data-memory access rules.
module tb_load_store_unit;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid, lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        lsu_busy, lsu_done, lsu_err;
   logic [31:0] lsu_rdata;
   int          checks = 0;
   int          errors = 0;

   lsu_if #(.MEM_ADDR_WIDTH(6)) mem_bus ();

   load_store_unit #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(6), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lsu_valid  (lsu_valid),
      .lsu_we     (lsu_we),
      .lsu_funct3 (lsu_funct3),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_busy   (lsu_busy),
      .lsu_done   (lsu_done),
      .lsu_err    (lsu_err),
      .lsu_rdata  (lsu_rdata),
      .mem        (mem_bus)
   );

   always #5 clk = ~clk;

   // Access size in bytes, lane offset, and everything derived from them.
   function automatic void ref_model(input logic we, input logic [2:0] f3,
         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
         output logic illegal, output logic [3:0] be, output logic [31:0] mwd,
         output logic [31:0] rd);
      int size, off;
      logic [31:0] v;
      size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off     = int'(addr % 4);
      illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4)
                || (off % size != 0);
      be      = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wdata[8*(i % size) +: 8];
      v = word >> (8 * off);
      if (size < 4) begin
         v = v & ((32'd1 << (8 * size)) - 1);
         if (f3 < 3'd4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
      end
      rd = we ? 32'd0 : v;
   endfunction

   task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
         input int rdy_dly, input int rsp_dly);
      logic illegal;
      logic [3:0] be;
      logic [31:0] mwd, rd;
      logic [45:0] exp_req, got_req;
      logic [33:0] exp_done, got_done;
      ref_model(we, f3, addr, wdata, word, illegal, be, mwd, rd);
      exp_req = {2'b10, 1'b1, we, be, addr[7:2], mwd};
      lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
      @(negedge clk);
      lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
      if (illegal) begin
         checks++;
         if (mem_bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s issue_err_req_valid got %b want 0", tag, mem_bus.mem_req_valid);
         end
      end else begin
         for (int c = 0; c <= rdy_dly; c++) begin
            got_req = {lsu_busy, lsu_done, mem_bus.mem_req_valid, mem_bus.mem_we,
                       mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata};
            checks++;
            if (got_req !== exp_req) begin
               errors++;
               $display("FAIL %s req_cycle%0d got %h want %h", tag, c, got_req, exp_req);
            end
            mem_bus.mem_req_ready = (c == rdy_dly);
            mem_bus.mem_rsp_valid = (c != rdy_dly) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
         end
         mem_bus.mem_req_ready = 1'b0;
         mem_bus.mem_rsp_valid = 1'b0;
         for (int c = 0; c <= rsp_dly; c++) begin
            checks++;
            if ({lsu_busy, lsu_done, mem_bus.mem_req_valid} !== 3'b100) begin
               errors++;
               $display("FAIL %s wait_cycle%0d got %b want 100", tag, c,
                        {lsu_busy, lsu_done, mem_bus.mem_req_valid});
            end
            if (c == rsp_dly) begin
               mem_bus.mem_rsp_valid = 1'b1;
               mem_bus.mem_rdata     = word;
            end
            @(negedge clk);
         end
         mem_bus.mem_rsp_valid = 1'b0;
         mem_bus.mem_rdata     = $urandom;
      end
      exp_done = {1'b1, illegal, illegal ? 32'd0 : rd};
      got_done = {lsu_done, lsu_err, lsu_rdata};
      checks++;
      if (got_done !== exp_done) begin
         errors++;
         $display("FAIL %s done_err_rdata got %h want %h", tag, got_done, exp_done);
      end
      @(negedge clk);
      checks++;
      if ({lsu_busy, lsu_done} !== 2'b00) begin
         errors++;
         $display("FAIL %s back_to_idle got %b want 00", tag, {lsu_busy, lsu_done});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rdata = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({lsu_busy, lsu_done, lsu_err, lsu_rdata, mem_bus.mem_req_valid, mem_bus.mem_we,
           mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata} !== 80'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b rdata=%h req=%b want all 0",
                  lsu_busy, lsu_done, lsu_err, lsu_rdata, mem_bus.mem_req_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_txn("sw_word",      1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 0, 0);
      run_txn("lb_neg",       1'b0, 3'b000, 32'h07, 32'h0, 32'h80FF1234, 0, 0);
      run_txn("lbu",          1'b0, 3'b100, 32'h07, 32'h0, 32'h80FF1234, 0, 0);
      run_txn("sh_upper",     1'b1, 3'b001, 32'h06, 32'h0000ABCD, 32'h0, 0, 0);
      run_txn("lhu_upper",    1'b0, 3'b101, 32'h06, 32'h0, 32'h7FFF0000, 0, 0);
      run_txn("lw_misalign",  1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 0, 0);
      run_txn("f3_011",       1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 0, 0);
      run_txn("store_unsgn",  1'b1, 3'b100, 32'h04, 32'h0, 32'h0, 0, 0);
      run_txn("lh_odd",       1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 0, 0);
      run_txn("stall3",       1'b1, 3'b000, 32'hFD, 32'h5A5A5AC3, 32'h0, 3, 2);
      run_txn("lh_neg_low",   1'b0, 3'b001, 32'h40, 32'h0, 32'h1234F00D, 1, 1);
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a;
      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_txn("random", 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_timeout(input logic accept);
      int k;
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h10;
      @(negedge clk);
      lsu_valid = 1'b0;
      mem_bus.mem_req_ready = accept;
      k = 1;
      while (!lsu_done && k < 2 * TMO) begin
         @(negedge clk);
         mem_bus.mem_req_ready = 1'b0;
         k++;
      end
      checks++;
      if (k !== TMO + 1) begin
         errors++;
         $display("FAIL timeout_cycle accept=%b got %0d want %0d", accept, k, TMO + 1);
      end
      checks++;
      if ({lsu_done, lsu_err, lsu_rdata} !== {2'b11, 32'd0}) begin
         errors++;
         $display("FAIL timeout_err got done=%b err=%b rdata=%h want 1 1 0",
                  lsu_done, lsu_err, lsu_rdata);
      end
      @(negedge clk);
      checks++;
      if ({lsu_busy, lsu_done} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_idle got %b want 00", {lsu_busy, lsu_done});
      end
   endtask

   task automatic test_midreset();
      run_txn("pre_reset", 1'b0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 0);
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h4;
      @(negedge clk);
      lsu_valid = 1'b0;
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_bus.mem_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({lsu_busy, lsu_done, lsu_err, lsu_rdata, mem_bus.mem_req_valid} !== 36'd0) begin
         errors++;
         $display("FAIL midreset_async got busy=%b done=%b rdata=%h want 0 0 0",
                  lsu_busy, lsu_done, lsu_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_bus.mem_rsp_valid = 1'b1;
      mem_bus.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_bus.mem_rsp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({lsu_busy, lsu_done, lsu_rdata} !== 34'd0) begin
            errors++;
            $display("FAIL late_rsp_ignored cycle%0d got busy=%b done=%b rdata=%h want 0",
                     c, lsu_busy, lsu_done, lsu_rdata);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
